// File: rtl/inst_fetch_unit_pkg.sv
// ============================================================================
// Module  : inst_fetch_unit_pkg
// Purpose : Shared constants and types for the LEGv8 instruction fetch unit.
//           INST_SIZE / DATA_SIZE mirror the datapath widths, the FSM state
//           encoding and the sequential PC increment live here as well.
// Ports   : none (package)
// Config  : IF_PERF_CNT_EN (used by inst_fetch_unit, not by this package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetch_unit_pkg;

  localparam int INST_SIZE = 32;
  localparam int DATA_SIZE = 64;
  localparam int PC_INC    = 4;

  typedef enum logic [1:0] {
    IF_ST_FETCH = 2'd0,
    IF_ST_WAIT  = 2'd1,
    IF_ST_DROP  = 2'd2
  } if_state_e;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_unit_if_fifo.sv
// ============================================================================
// Module  : if_fifo
// Purpose : Small synchronous FIFO holding {inst, inst_pc} entries between
//           instruction memory and decode. Supports simultaneous push/pop and
//           a synchronous flush that empties it in one cycle.
// Ports   : clk, rst_n (async, active-low)
//           flush            - drop all entries
//           push, push_data  - write one entry
//           pop              - consume head (ignored when empty)
//           head_data        - registered storage at the read pointer
//           full, empty, count
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop & ~empty;
  // A full FIFO can still take a word if the head leaves in the same cycle.
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module  : inst_fetch_unit
// Purpose : Instruction fetch for the LEGv8 datapath. Holds the PC, issues
//           one word read at a time to instruction memory, buffers returned
//           words in if_fifo and hands {inst, inst_pc} to decode. A redirect
//           from EX flushes the buffer, drops any in-flight response and
//           restarts fetching at the branch target.
// Ports   : clk, rst_n (async, active-low)
//           imem_req_valid/ready/addr  - request channel to instruction memory
//           imem_rsp_valid/data        - in-order response, never stalled
//           inst_valid/ready, inst, inst_pc - decode interface
//           redirect_valid, redirect_pc    - taken branch from EX
//           perf_fetched, perf_flushed     - only with IF_PERF_CNT_EN
// Config  : IF_PERF_CNT_EN - adds saturating push / flush event counters
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = DATA_SIZE,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ADDR_W-1:0]    imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INST_SIZE-1:0] imem_rsp_data,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [INST_SIZE-1:0] inst,
  output logic [ADDR_W-1:0]    inst_pc,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_flushed
`endif
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = INST_SIZE + ADDR_W;

  if_state_e          state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_addr_q;   // address of the request now in flight
  logic               req_valid_q;
  logic               req_fire;
  logic               pop;
  logic               push;
  logic               fetch_next;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_n;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic               unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;
  assign req_fire       = req_valid_q & imem_req_ready;
  assign pop            = ~fifo_empty & inst_ready;
  assign inst_valid     = ~fifo_empty;
  assign inst           = head[ENTRY_W-1 -: INST_SIZE];
  assign inst_pc        = head[ADDR_W-1:0];

  // Only an undisturbed WAIT response is kept; redirect-cycle and DROP
  // responses are thrown away.
  assign push = (state == IF_ST_WAIT) & imem_rsp_valid & ~redirect_valid & ~fifo_full;

  // The FSM lands in FETCH next cycle under the same conditions whether or
  // not a redirect is present: FETCH stays unless a request fired, WAIT and
  // DROP leave on the response.
  assign fetch_next = (state == IF_ST_FETCH) ? ~req_fire : imem_rsp_valid;

  // Occupancy after this edge; drives the credit check for the registered
  // request valid so a new request never outruns the buffer space.
  assign count_n = redirect_valid ? '0
                 : fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IF_ST_FETCH;
      pc          <= RESET_PC;
      req_addr_q  <= '0;
      req_valid_q <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        unique case (state)
          IF_ST_FETCH: state <= req_fire ? IF_ST_DROP : IF_ST_FETCH;
          default:     state <= imem_rsp_valid ? IF_ST_FETCH : IF_ST_DROP;
        endcase
      end else begin
        unique case (state)
          IF_ST_FETCH: if (req_fire) begin
            pc    <= pc + ADDR_W'(PC_INC);
            state <= IF_ST_WAIT;
          end
          IF_ST_WAIT,
          IF_ST_DROP:  if (imem_rsp_valid) state <= IF_ST_FETCH;
          default:     state <= IF_ST_FETCH;
        endcase
      end
      req_valid_q <= fetch_next && (count_n < CNT_W'(FIFO_DEPTH));
      if (req_fire) req_addr_q <= pc;
    end
  end

  if_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rsp_data, req_addr_q}),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef IF_PERF_CNT_EN
  logic             discard;
  logic [CNT_W-1:0] flushed_entries;
  logic [32:0]      fetched_sum;
  logic [32:0]      flushed_sum;

  assign discard = imem_rsp_valid & (state != IF_ST_FETCH)
                 & (redirect_valid | (state == IF_ST_DROP));
  // The word popped in the redirect cycle was delivered, not flushed.
  assign flushed_entries = redirect_valid ? fifo_count - CNT_W'(pop) : '0;
  assign fetched_sum = {1'b0, perf_fetched} + 33'(push);
  assign flushed_sum = {1'b0, perf_flushed} + 33'(flushed_entries) + 33'(discard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module  : tb_inst_fetch_unit
// Purpose : Self-checking bench for inst_fetch_unit. An instruction-memory
//           model answers accepted requests in order after a random latency;
//           a stream-level reference model tracks the next PC decode must see
//           and the next PC that must be requested, restarting both at every
//           redirect target.
// Config  : IF_PERF_CNT_EN - perf ports are connected when defined
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;

  localparam int AW    = 64;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_flushed;
`endif

  inst_fetch_unit #(
    .ADDR_W     (AW),
    .RESET_PC   (64'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction memory image: the first three words are the LEGv8 sequence
  // from the bring-up program, everything else is a scrambled address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    case (a)
      64'h0:   return 32'hF84402C9;
      64'h4:   return 32'h8B09026A;
      64'h8:   return 32'hCB0A028B;
      default: begin
        h = a[31:0] * 32'h9E3779B1;
        return h ^ {h[15:0], h[31:16]} ^ a[63:32];
      end
    endcase
  endfunction

  // Memory model state
  logic [63:0] q_addr[$];
  int          q_due[$];
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // Stimulus controls
  int          ready_mode = 1;       // 0 never, 1 always, 2 random, 3 stall addr 8
  int          inst_ready_mode = 1;  // 0 never, 1 always, 2 random
  int          redir_permille = 0;
  int          hold8 = 0;
  logic        force_redir = 1'b0;
  logic [63:0] force_target = '0;
  logic        redir_on_rsp = 1'b0;
  logic        lat_check = 1'b0;

  // Reference model and observation
  logic [63:0] exp_pc = '0;
  logic [63:0] req_pc = '0;
  int          n_pop = 0;
  int          n_fire = 0;
  logic [63:0] last_fire_addr = '1;
  logic        want_first = 1'b0;
  logic [63:0] first_fire_after_redir = '1;
  logic [63:0] watch_pc = '1;
  logic        saw_watch = 1'b0;
  logic        hold_pending = 1'b0;
  logic [63:0] hold_addr = '0;
  logic        prev_rsp = 1'b0;

  task automatic run_cycle();
    int   qsz;
    logic fire;
    logic pop;
    @(negedge clk);
    cyc++;

    if (hold_pending) begin
      check_val("req_hold_valid", imem_req_valid, 1);
      check_val("req_hold_addr", imem_req_addr, hold_addr);
    end
    if (lat_check && prev_rsp) check_val("rsp_to_inst_valid", inst_valid, 1);

    qsz = q_addr.size();
    if (qsz > 0 && cyc >= q_due[0]) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end

    case (ready_mode)
      0: imem_req_ready = 1'b0;
      1: imem_req_ready = 1'b1;
      2: imem_req_ready = ($urandom_range(99) < 75);
      default: begin
        if (imem_req_valid && imem_req_addr == 64'h8 && hold8 < 3) begin
          imem_req_ready = 1'b0;
          hold8++;
        end else imem_req_ready = 1'b1;
      end
    endcase

    case (inst_ready_mode)
      0: inst_ready = 1'b0;
      1: inst_ready = 1'b1;
      default: inst_ready = ($urandom_range(99) < 70);
    endcase

    redirect_valid = 1'b0;
    redirect_pc    = {$urandom, $urandom};
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_target;
      force_redir    = 1'b0;
    end else if (redir_on_rsp && imem_rsp_valid) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_target;
      redir_on_rsp   = 1'b0;
    end else if (redir_permille > 0 && $urandom_range(999) < redir_permille) begin
      redirect_valid = 1'b1;
      redirect_pc    = 64'($urandom_range(4095));
    end

    fire = imem_req_valid && imem_req_ready;
    pop  = inst_valid && inst_ready;

    if (pop) begin
      check_val("inst_pc", inst_pc, exp_pc);
      check_val("inst", inst, mem_word(exp_pc));
      if (inst_pc == watch_pc) saw_watch = 1'b1;
      exp_pc += 64'd4;
      n_pop++;
    end
    if (fire) begin
      check_val("one_outstanding", qsz, 0);
      check_val("req_addr", imem_req_addr, req_pc);
      if (want_first) begin
        first_fire_after_redir = imem_req_addr;
        want_first = 1'b0;
      end
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      last_fire_addr = imem_req_addr;
      req_pc += 64'd4;
      n_fire++;
    end
    if (redirect_valid) begin
      exp_pc     = {redirect_pc[63:2], 2'b00};
      req_pc     = {redirect_pc[63:2], 2'b00};
      want_first = 1'b1;
    end

    hold_pending = imem_req_valid && !imem_req_ready && !redirect_valid;
    hold_addr    = imem_req_addr;
    prev_rsp     = imem_rsp_valid && !redirect_valid;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_inst_valid", inst_valid, 0);
    check_val("rst_req_valid", imem_req_valid, 0);
    check_val("rst_inst", inst, 0);
    check_val("rst_inst_pc", inst_pc, 0);
    q_addr.delete();
    q_due.delete();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    exp_pc         = '0;
    req_pc         = '0;
    hold_pending   = 1'b0;
    prev_rsp       = 1'b0;
    want_first     = 1'b0;
    force_redir    = 1'b0;
    redir_on_rsp   = 1'b0;
    last_fire_addr = '1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int f0;
  int p0;
  int k;

  initial begin
    do_reset();

    // Straight-line fetch: 0, 4, 8 ... with 1-cycle memory
    ready_mode = 1; inst_ready_mode = 1; lat_min = 1; lat_max = 1; lat_check = 1'b1;
    repeat (12) run_cycle();
    lat_check = 1'b0;
    check_val("seq_progress", (n_pop >= 4), 1);

    // Decode stalled: the buffer fills and requests stop
    inst_ready_mode = 0;
    repeat (5) run_cycle();
    f0 = n_fire;
    repeat (5) run_cycle();
    check_val("stall_no_new_req", n_fire - f0, 0);
    check_val("stall_req_valid", imem_req_valid, 0);
    check_val("stall_inst_valid", inst_valid, 1);
    ready_mode = 0; inst_ready_mode = 1; p0 = n_pop;
    repeat (5) run_cycle();
    check_val("buffered_words", n_pop - p0, DEPTH);
    ready_mode = 1;
    repeat (6) run_cycle();

    // Memory not ready on address 0x8 for three cycles
    do_reset();
    ready_mode = 3; hold8 = 0;
    repeat (16) run_cycle();
    check_val("addr8_stall_cycles", hold8, 3);
    check_val("addr8_progress", (n_fire > 0 && req_pc > 64'h8), 1);

    // Redirect to 0x40 while the 0xC fetch is in flight
    do_reset();
    ready_mode = 1; lat_min = 3; lat_max = 3;
    k = 0;
    while (last_fire_addr != 64'hC && k < 40) begin
      run_cycle();
      k++;
    end
    check_val("reach_addr_c", last_fire_addr, 64'hC);
    force_redir = 1'b1; force_target = 64'h40; watch_pc = 64'h40; saw_watch = 1'b0;
    repeat (20) run_cycle();
    check_val("redir40_first_req", first_fire_after_redir, 64'h40);
    check_val("redir40_inst_seen", saw_watch, 1);

    // Redirect to 0x103 in the same cycle as a response
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (6) run_cycle();
    redir_on_rsp = 1'b1; force_target = 64'h103; watch_pc = 64'h100; saw_watch = 1'b0;
    repeat (20) run_cycle();
    check_val("redir103_used", redir_on_rsp, 0);
    check_val("redir103_first_req", first_fire_after_redir, 64'h100);
    check_val("redir103_inst_seen", saw_watch, 1);

    // Reset while a fetch is outstanding and the buffer holds a word
    do_reset();
    lat_min = 6; lat_max = 6; inst_ready_mode = 0;
    f0 = n_fire; k = 0;
    while (n_fire - f0 < 2 && k < 40) begin
      run_cycle();
      k++;
    end
    check_val("pre_reset_second_req", n_fire - f0, 2);
    check_val("pre_reset_inst_valid", inst_valid, 1);
    do_reset();

    // Random traffic with redirects
    ready_mode = 2; inst_ready_mode = 2; lat_min = 1; lat_max = 4; redir_permille = 40;
    repeat (700) run_cycle();
    do_reset();
    repeat (700) run_cycle();

    // Drain: everything must keep flowing
    ready_mode = 1; inst_ready_mode = 1; lat_min = 1; lat_max = 1; redir_permille = 0;
    p0 = n_pop;
    repeat (40) run_cycle();
    check_val("drain_progress", (n_pop - p0 >= 10), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction producer for the LEGv8 datapath; it is the upstream end of the instruction word that the control path decodes.
- Holds the PC and issues word reads to instruction memory over a valid/ready request plus valid response interface.
- Buffers returned words in a small FIFO and presents {inst, inst_pc} to decode with valid/ready.
- Applies branch redirects from EX: flushes buffered and in-flight fetches, then restarts at the target.

Parameters:
- RESET_PC, 64'h0, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, at least 2).
- ADDR_W, 64, PC width (the `DATA_SIZE` of the datapath).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  word address; bits [1:0] always 0
- imem_rsp_valid  in  1  response valid, one per accepted request, in order, latency at least 1 cycle
- imem_rsp_data  in  `INST_SIZE  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes
- inst  out  `INST_SIZE  instruction word (opcode = inst[31:21])
- inst_pc  out  ADDR_W  address of inst
- redirect_valid  in  1  taken branch from EX
- redirect_pc  in  ADDR_W  branch target; bits [1:0] ignored, treated as 0

Behaviour:
- Reset (asynchronous, active-low):
  - pc = RESET_PC; FIFO empty; FSM = FETCH.
  - imem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0.
- At most one request outstanding.
- Credit rule: a request is issued only when FIFO occupancy plus outstanding count is less than FIFO_DEPTH. A response therefore always has space and imem_rsp_valid is never back-pressured.
- FSM states:
  - FETCH: imem_req_valid = 1 when credit is available. On req_valid & req_ready, pc <= pc + 4 (wraps modulo 2^ADDR_W) and go to WAIT.
  - WAIT: imem_req_valid = 0. On rsp_valid, push {rsp_data, request address} and go to FETCH. A new request is issued no earlier than the cycle after the response (request-to-request spacing is at least 2 cycles).
  - DROP: entered when a redirect occurs in WAIT. The next rsp_valid is discarded (not pushed), then go to FETCH.
- Request address is held stable while req_valid = 1 and req_ready = 0. A request is never withdrawn except by redirect, which may drop req_valid in the following cycle.
- Redirect takes priority over all other events in the same cycle:
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; FIFO flushed.
  - A pop on inst_ready in the redirect cycle is still completed (the word was already consumed).
  - State transitions: FETCH with handshake in the same cycle goes to DROP; WAIT goes to DROP; DROP stays in DROP; otherwise FETCH.
  - A response arriving in the redirect cycle is discarded. If it was the one awaited in DROP, go to FETCH.
  - First request to the new target appears 1 cycle after redirect at the earliest.
- Output path: inst_valid = FIFO non-empty; inst/inst_pc = FIFO head (registered storage).
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle are both allowed.
  - Full FIFO with no pop: no new request.
- Latency: a response at cycle t makes inst_valid = 1 at cycle t+1 when the FIFO was empty.
- Back-to-back redirects: each one restarts at its own target; only the last target survives.
- Reset asserted mid-transaction: all state is cleared immediately. The bench must also reset imem (no stale response is tolerated after reset).

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] (increments per FIFO push) and perf_flushed[31:0] (increments by the number of flushed FIFO entries plus discarded responses).
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package common.vh (existing):
  - Reuse `INST_SIZE and `DATA_SIZE.
  - Add `IF_ST_FETCH = 2'd0, `IF_ST_WAIT = 2'd1, `IF_ST_DROP = 2'd2.
  - Add `PC_INC = 4.
- Sub-module if_fifo: synchronous FIFO with flush input, width `INST_SIZE+ADDR_W, depth FIFO_DEPTH, outputs full/empty/count.

Test Plan:
- Reset, memory always ready with 1-cycle latency, inst_ready = 1 -> addresses 0, 4, 8, … issued; inst sequence F84402C9, 8B09026A, CB0A028B with inst_pc 0, 4, 8.
- inst_ready = 0 for 10 cycles -> exactly FIFO_DEPTH (2) words buffered, imem_req_valid = 0. Release -> order preserved and no loss.
- imem_req_ready = 0 for 3 cycles with addr 0x8 -> addr held at 0x8 and pc not advanced.
- Redirect to 0x40 while waiting on 0xC (latency 3) -> response for 0xC discarded, FIFO flushed, next request is 0x40, next inst_pc = 0x40.
- Redirect to 0x103 in the same cycle as a response -> response dropped, next request address 0x100.
- With IF_PERF_CNT_EN defined, run the redirect scenario -> perf_flushed equals flushed entries + 1. Assert rst_n mid-WAIT -> counters 0 and inst_valid 0 immediately.
